// File: rtl/op_arbiter.sv
// Round-robin arbiter that fetches operand pairs from num_req requesters,
// runs each pair through one shared add/sub/mul unit and hands the result downstream.
module op_arbiter #(
  parameter int    data_width = 32,
  parameter int    num_req    = 4,
  parameter string op         = "add"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_req-1:0]              in_pend,
  output logic [num_req-1:0]              in_req,
  input  logic [num_req-1:0]              in_ack,
  input  logic [2*data_width*num_req-1:0] in_data,
  input  logic                            out_req,
  output logic                            out_ack,
  output logic [data_width-1:0]           out_data,
  output logic [2:0]                      out_src,
  output logic                            busy,
  output logic [31:0]                     served
);

  localparam int idx_w = (num_req > 1) ? $clog2(num_req) : 1;
  typedef logic [idx_w-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    EXEC    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  idx_t                  grant;
  idx_t                  last;
  idx_t                  pick;
  logic                  pick_valid;
  int                    cand;
  logic                  start;
  logic                  take;
  logic                  deliver;
  logic [data_width-1:0] op_a;
  logic [data_width-1:0] op_b;
  logic [data_width-1:0] result;
  logic [data_width-1:0] opa_arr [num_req];
  logic [data_width-1:0] opb_arr [num_req];

  for (genvar i = 0; i < num_req; i++) begin : g_split
    assign opa_arr[i] = in_data[2*data_width*i +: data_width];
    assign opb_arr[i] = in_data[2*data_width*i + data_width +: data_width];
  end

  // Shared unit; results wrap to data_width bits.
  function automatic logic [data_width-1:0] exec_op(input logic [data_width-1:0] a,
                                                    input logic [data_width-1:0] b);
    if (op == "sub") begin
      exec_op = a - b;
    end else if (op == "mul") begin
      exec_op = a * b;
    end else begin
      exec_op = a + b;
    end
  endfunction

  // Round-robin pick: scanning downward leaves the smallest offset after last.
  always_comb begin
    pick = '0;
    cand = 0;
    for (int k = num_req; k >= 1; k--) begin
      cand = int'(last) + k;
      cand = (cand >= num_req) ? cand - num_req : cand;
      pick = in_pend[idx_t'(cand)] ? idx_t'(cand) : pick;
    end
    pick_valid = |in_pend;
  end

  // Next-state and single-cycle action strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    take       = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = FETCH;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: begin
        if (in_ack[grant]) begin
          state_next = EXEC;
          take       = 1'b1;
        end else begin
          state_next = FETCH;
        end
      end
      EXEC: begin
        state_next = DELIVER;
      end
      DELIVER: begin
        if (out_req && !out_ack) begin
          state_next = IDLE;
          deliver    = 1'b1;
        end else begin
          state_next = DELIVER;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      last     <= idx_t'(num_req - 1);
      in_req   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      out_ack  <= 1'b0;
      out_data <= '0;
      out_src  <= 3'd0;
      busy     <= 1'b0;
      served   <= 32'd0;
    end else begin
      out_ack <= deliver;
      busy    <= (state_next != IDLE);
      if (start) begin
        grant  <= pick;
        in_req <= {{(num_req-1){1'b0}}, 1'b1} << pick;
      end else if (take) begin
        op_a   <= opa_arr[grant];
        op_b   <= opb_arr[grant];
        in_req <= '0;
      end else begin
        in_req <= in_req;
      end
      if (state == EXEC) begin
        result <= exec_op(op_a, op_b);
      end else begin
        result <= result;
      end
      if (deliver) begin
        out_data <= result;
        out_src  <= 3'(grant);
        last     <= grant;
        served   <= served + 32'd1;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: doc/op_arbiter.md
OP_ARBITER -- requirements
Module: op_arbiter

Interface
REQ-001 Parameter data_width, default 32, operand and result width in bits.
REQ-002 Parameter num_req, default 4, number of requester channels (2..8).
REQ-003 Parameter op, default "add", shared-unit function: "add" (a+b), "sub" (a-b) or "mul" (a*b).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_pend  input  num_req  level; bit i high means requester i has an operand pair ready.
REQ-007 in_req  output  num_req  arbiter fetch request, one-hot or zero.
REQ-008 in_ack  input  num_req  requester one-cycle acknowledge; operands valid in the same cycle.
REQ-009 in_data  input  2*data_width*num_req  operand pairs; slice i is {b,a}, with a in the low half.
REQ-010 out_req  input  1  downstream result request, level.
REQ-011 out_ack  output  1  one-cycle result-valid pulse.
REQ-012 out_data  output  data_width  result, held until the next out_ack.
REQ-013 out_src  output  3  index of the requester that produced out_data, held with out_data.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 served  output  32  count of completed results.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FETCH, EXEC, DELIVER.
REQ-017 IDLE, when any in_pend bit is high: grant g = first set index scanning last+1, last+2, ... modulo num_req; set in_req[g]; go to FETCH.
REQ-018 IDLE with in_pend all zero SHALL remain in IDLE with in_req zero.
REQ-019 FETCH: in_req[g] SHALL stay high until in_ack[g] is sampled high.
REQ-020 On in_ack[g] the arbiter SHALL capture in_data slice g, clear in_req[g] on the same edge and go to EXEC.
REQ-021 In any state, in_ack on a non-granted index SHALL be ignored: no capture, no state change.
REQ-022 A deasserted in_pend[g] during FETCH SHALL NOT cancel the fetch.
REQ-023 EXEC: result = op(a,b), truncated to the low data_width bits; wraparound, no saturation; then go to DELIVER; exactly 1 cycle.
REQ-024 DELIVER: when out_req is high and out_ack is low, the arbiter SHALL on that edge:
  - pulse out_ack for one cycle;
  - load out_data = result and out_src = g;
  - set last = g;
  - increment served (wraps at 2^32);
  - go to IDLE.
REQ-025 DELIVER SHALL hold indefinitely while out_req is low; no new fetch starts.
REQ-026 out_ack SHALL never be high on two consecutive cycles.
REQ-027 Minimum turnaround, in_ack edge to out_ack high, SHALL be 2 cycles when out_req is already high.
REQ-028 Fairness: with all in_pend bits continuously high, grants SHALL rotate 0,1,...,num_req-1,0 with no index repeated before every other index has been served.

Reset
REQ-029 With rst high the arbiter SHALL set:
  - state to IDLE;
  - in_req, out_ack, out_data, out_src, busy and served to 0;
  - last to num_req-1, so the first grant is index 0.
REQ-030 rst asserted mid-operation (FETCH, EXEC or DELIVER) SHALL abandon the transaction without emitting out_ack; in_req SHALL be 0 on the cycle after rst is sampled.
REQ-031 in_ack or out_req arriving while rst is high SHALL be ignored.

Verification
REQ-032 Single request: in_pend=4'b0100, requester 2 acks with a=5, b=7, out_req held high, op="add" -> in_req=4'b0100 for one fetch; out_ack pulses once with out_data=12 and out_src=2; served=1.
REQ-033 Round robin: in_pend=4'b1111 continuously, each requester supplies a=i, b=10 -> out_src sequence 0,1,2,3,0 and out_data sequence 10,11,12,13,10.
REQ-034 Back-pressure: out_req low for 20 cycles after EXEC -> state stays DELIVER, busy=1, out_ack=0, in_req=0 throughout; out_ack fires the first cycle after out_req rises.
REQ-035 Wraparound: op="add", a=32'hFFFFFFFF, b=2 -> out_data=1; op="mul", a=32'h10000, b=32'h10000 -> out_data=0.
REQ-036 Spurious ack: while granted index 1 is in FETCH, pulse in_ack[3] with a=99 -> no capture and no state change; the later in_ack[1] with a=1, b=1 yields out_data=2 and out_src=1.
REQ-037 Reset in EXEC: assert rst for 1 cycle -> no out_ack, served=0; the next grant with in_pend=4'b1111 goes to index 0.
